matmul_sequencer: RTL
=====================

// Module: matmul_sequencer
// PURPOSE
//  Control FSM for the matrixMult datapath. On start it walks every (batch row, output feature)
//  pair, drives inputAddr/weightAddr to the input and weight buffers, and aligns MAC enable/clear
//  with buffer read latency. It issues outputWrEn/outputAddr once per finished batch row.
//  Sits between the host start/done handshake and the matrixMult datapath plus its SRAMs.
// PARAMETERS
//  LOG_BATCH_SIZE       3  log2 of batch rows (8 rows)
//  LOG_OUTPUT_FEATURES  3  log2 of output features (8 features)
//  MEM_LATENCY          1  cycles from address to data at datapath inputs (>=1)
//  MAC_LATENCY          2  cycles from last macEn of a row to result valid at outputData (>=1)
// PORTS
//  clk         in   1                    rising-edge clock
//  reset       in   1                    asynchronous, active-high reset
//  start       in   1                    level; sampled only in IDLE
//  busy        out  1                    high while a job is in flight
//  done        out  1                    one-cycle pulse at job completion
//  inputAddr   out  LOG_BATCH_SIZE       input buffer read address (batch row)
//  weightAddr  out  LOG_OUTPUT_FEATURES  weight buffer read address (output feature)
//  macEn       out  1                    datapath: inputData/weightData valid this cycle
//  macClear    out  1                    datapath: first feature of row, load not accumulate
//  outputAddr  out  LOG_BATCH_SIZE       output buffer write address
//  outputWrEn  out  1                    output buffer write strobe
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; all outputs 0; delay-line flags cleared; counters 0.
//  - States: IDLE -> ISSUE -> DRAIN -> IDLE.
//    IDLE:  start=1 at edge N -> ISSUE. busy=1 from cycle N+1.
//    ISSUE: one address pair per cycle. f increments; on f wrap, b increments.
//           Issue k (0..2^(LB+LF)-1) is presented in cycle N+1+k with b=k>>LF, f=k&(2^LF-1).
//           After issuing b=max, f=max -> DRAIN.
//    DRAIN: addresses held at 0; waits for the pipeline to empty; final cycle -> IDLE.
//  - Addresses are 0 outside ISSUE and wrap naturally at their widths.
//  - Read alignment: macEn=1 in cycle N+1+k+MEM_LATENCY. macClear=1 in the same cycle iff f==0.
//  - Write: row r writes in cycle N+1+(r*2^LF + 2^LF-1)+MEM_LATENCY+MAC_LATENCY with outputAddr=r.
//    outputAddr is 0 whenever outputWrEn=0.
//  - done pulses in the same cycle as the final row's outputWrEn. busy falls the cycle after.
//  - start while busy is ignored, with no queuing.
//  - start still high on the cycle after done: a new job starts immediately.
//  - Defaults: 64 issue cycles; done at cycle N+1+63+3 = N+67.
//  - Rows do not overlap: back-to-back rows are pipelined; no bubble between rows.
//  - Reset mid-ISSUE or mid-DRAIN aborts silently: no further macEn, outputWrEn or done.
// STRUCTURE
//  - Shared header matmul_defs.vh holds:
//    - state encodings (IDLE/ISSUE/DRAIN)
//    - default LOG_BATCH_SIZE, LOG_OUTPUT_FEATURES, MEM_LATENCY, MAC_LATENCY
//    These are shared with matrixMult and its bench.
//  - One sub-module, matmul_delay_line:
//    - parameterised WIDTH x DEPTH shift register with async reset
//    - carries {valid, first, last, row} through MEM_LATENCY and MAC_LATENCY stages
//  - Top: FSM + batch/feature counters + DRAIN counter.
// TESTING
//  1. Reset 3 cycles, start=0 for 10 cycles -> all outputs 0, busy=0.
//  2. Single job: start pulse at edge N.
//     - inputAddr/weightAddr sequence 0/0,0/1..0/7,1/0..7/7 in cycles N+1..N+64.
//     - macEn high in N+2..N+65; macClear at N+2,N+10,..,N+58.
//  3. Same job: outputWrEn with outputAddr 0..7 at N+11,N+19,..,N+67.
//     - done only at N+67; busy N+1..N+67.
//  4. start held high continuously -> second job's first address issue at N+69.
//     - start pulses during busy are ignored: exactly 8 writes per job.
//  5. Reset asserted at N+30 for 1 cycle -> all outputs 0 by N+30.
//     - no outputWrEn/done afterwards; a fresh start then runs a clean 64-issue job.
//  6. MEM_LATENCY=3, MAC_LATENCY=1 build.
//     - macEn lags addresses by 3 cycles; row-0 write at N+12; done at N+68.

Source files
------------

// File: rtl/matmul_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// matmul_sequencer_pkg
//   Definitions shared by the matrixMult sequencer, its datapath and benches:
//   FSM state encodings and the default geometry and latency parameters.
// -----------------------------------------------------------------------------
package matmul_sequencer_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Default geometry: 8 batch rows x 8 output features
  localparam int DEF_LOG_BATCH_SIZE      = 3;
  localparam int DEF_LOG_OUTPUT_FEATURES = 3;

  // Default latencies: buffer read, and last macEn to result valid
  localparam int DEF_MEM_LATENCY = 1;
  localparam int DEF_MAC_LATENCY = 2;

endpackage

// File: rtl/matmul_sequencer_delay_line.sv
// -----------------------------------------------------------------------------
// matmul_delay_line
//   WIDTH x DEPTH shift register with asynchronous reset. Used by the
//   sequencer to carry per-issue control tags ({valid, first, last, row})
//   across the buffer read latency and the MAC latency.
// Ports
//   clk    in  1      rising-edge clock
//   reset  in  1      asynchronous, active-high; clears every stage
//   din    in  WIDTH  tag entering the line
//   dout   out WIDTH  tag delayed by exactly DEPTH cycles
// -----------------------------------------------------------------------------
module matmul_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/matmul_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_sequencer
//   Control FSM for the matrixMult datapath. On start it walks every
//   (batch row, output feature) pair, one per cycle, drives the input/weight
//   buffer read addresses, and delays the MAC enable/clear by the buffer read
//   latency. One output-buffer write is issued per finished batch row, and
//   done pulses with the final row's write.
// Ports
//   clk         in  1    rising-edge clock
//   reset       in  1    asynchronous, active-high
//   start       in  1    level; sampled only in IDLE
//   busy        out 1    high while a job is in flight
//   done        out 1    one-cycle pulse at job completion
//   inputAddr   out LB   input buffer read address (batch row)
//   weightAddr  out LF   weight buffer read address (output feature)
//   macEn       out 1    datapath operands valid this cycle
//   macClear    out 1    first feature of a row: load instead of accumulate
//   outputAddr  out LB   output buffer write address (0 when not writing)
//   outputWrEn  out 1    output buffer write strobe
// -----------------------------------------------------------------------------
module matmul_sequencer
  import matmul_sequencer_pkg::*;
#(
  parameter int LOG_BATCH_SIZE      = DEF_LOG_BATCH_SIZE,
  parameter int LOG_OUTPUT_FEATURES = DEF_LOG_OUTPUT_FEATURES,
  parameter int MEM_LATENCY         = DEF_MEM_LATENCY,
  parameter int MAC_LATENCY         = DEF_MAC_LATENCY
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [LOG_BATCH_SIZE-1:0]      inputAddr,
  output logic [LOG_OUTPUT_FEATURES-1:0] weightAddr,
  output logic                           macEn,
  output logic                           macClear,
  output logic [LOG_BATCH_SIZE-1:0]      outputAddr,
  output logic                           outputWrEn
);

  localparam int LB           = LOG_BATCH_SIZE;
  localparam int LF           = LOG_OUTPUT_FEATURES;
  // DRAIN lasts exactly as long as the tail of the last issue takes to
  // reach the output write, so done lands on DRAIN's final cycle.
  localparam int DRAIN_CYCLES = MEM_LATENCY + MAC_LATENCY;
  localparam int DW           = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  logic [1:0]    state;
  logic [LB-1:0] batchCnt;
  logic [LF-1:0] featCnt;
  logic [DW-1:0] drainCnt;

  logic          issuing;
  logic          lastIssue;

  assign issuing   = (state == ST_ISSUE);
  assign lastIssue = issuing && (&batchCnt) && (&featCnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      batchCnt <= '0;
      featCnt  <= '0;
      drainCnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // Counters wrap back to 0 on the last issue, ready for the next job
          featCnt <= featCnt + 1'b1;
          if (&featCnt) batchCnt <= batchCnt + 1'b1;
          if (lastIssue) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drainCnt == DRAIN_LAST) begin
            drainCnt <= '0;
            state    <= ST_IDLE;
          end else begin
            drainCnt <= drainCnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p0: issue cycle (addresses presented) ----
  logic          vld_p0, first_p0, last_p0;
  logic [LB-1:0] row_p0;

  assign vld_p0     = issuing;
  assign first_p0   = issuing && (featCnt == '0);
  assign last_p0    = issuing && (&featCnt);
  assign row_p0     = issuing ? batchCnt : '0;
  assign inputAddr  = issuing ? batchCnt : '0;
  assign weightAddr = issuing ? featCnt  : '0;

  // ---- stage p1: operands at datapath inputs (after MEM_LATENCY) ----
  logic          vld_p1, first_p1, last_p1;
  logic [LB-1:0] row_p1;

  matmul_delay_line #(
    .WIDTH (LB + 3),
    .DEPTH (MEM_LATENCY)
  ) memDelay (
    .clk   (clk),
    .reset (reset),
    .din   ({vld_p0, first_p0, last_p0, row_p0}),
    .dout  ({vld_p1, first_p1, last_p1, row_p1})
  );

  assign macEn    = vld_p1;
  assign macClear = vld_p1 && first_p1;

  // ---- stage p2: row result valid (after MAC_LATENCY) ----
  logic          wrIn_p1;
  logic [LB-1:0] wrRowIn_p1;
  logic          vld_p2;
  logic [LB-1:0] row_p2;

  // Only the last feature of a row travels on; the row tag is zeroed
  // otherwise so outputAddr reads 0 whenever no write is happening.
  assign wrIn_p1    = vld_p1 && last_p1;
  assign wrRowIn_p1 = wrIn_p1 ? row_p1 : '0;

  matmul_delay_line #(
    .WIDTH (LB + 1),
    .DEPTH (MAC_LATENCY)
  ) macDelay (
    .clk   (clk),
    .reset (reset),
    .din   ({wrIn_p1, wrRowIn_p1}),
    .dout  ({vld_p2, row_p2})
  );

  assign outputWrEn = vld_p2;
  assign outputAddr = row_p2;
  assign done       = vld_p2 && (&row_p2);
  assign busy       = (state != ST_IDLE);

endmodule
